// File: rtl/sysserv_pkg.sv
// Shared definitions for the PolarFire system-services sequencer:
// FSM state encodings, service opcodes, default APB addresses and
// the mailbox address helper.
package sysserv_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_CMD_SETUP  = 3'd1;
  localparam state_t ST_CMD_ACCESS = 3'd2;
  localparam state_t ST_WAIT_RISE  = 3'd3;
  localparam state_t ST_WAIT_FALL  = 3'd4;
  localparam state_t ST_RD_SETUP   = 3'd5;
  localparam state_t ST_RD_ACCESS  = 3'd6;
  localparam state_t ST_DONE       = 3'd7;

  localparam logic [7:0] OP_SN  = 8'h00;
  localparam logic [7:0] OP_DV  = 8'h44;
  localparam logic [7:0] OP_IAP = 8'h42;

  localparam logic [31:0] CMD_ADDR_DFLT = 32'h0000_0000;
  localparam logic [31:0] MBX_BASE_DFLT = 32'h0000_0100;

  // Mailbox word k lives at base + 4*k; 32-bit wrap is not a concern.
  function automatic logic [31:0] mbx_addr(input logic [31:0] base, input logic [3:0] k);
    return base + {26'd0, k, 2'b00};
  endfunction

endpackage

// File: rtl/sysserv_sequencer_rr_arb.sv
// Round-robin arbiter for NREQ requesters. The search starts at the
// index after the previous winner; the pointer moves only when the
// sequencer strobes advance at the end of a transaction.
module sysserv_rr_arb #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  input  logic [IW-1:0]   winner,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] ptr;
  int            cand;

  // First requesting index at or after ptr, wrapping around.
  always_comb begin
    grant = '0;
    idx   = ptr;
    any   = 1'b0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = IW'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

  // Priority pointer: one past the last winner, so index 0 leads after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
  end

endmodule

// File: rtl/sysserv_sequencer.sv
// System-services sequencer: arbitrates fabric requesters, writes the
// service command over APB, follows USR_BUSY through rise and fall,
// then reads back rdlen mailbox words to the current owner.
// Optional macro SYSSERV_TIMEOUT_EN bounds the busy wait by TIMEOUT_CYC cycles.
//
// state      | meaning
// -----------+--------------------------------------------------
// IDLE       | arbitrate when SS_BUSY is low
// CMD_SETUP  | APB setup phase of the command write
// CMD_ACCESS | APB access phase of the command write
// WAIT_RISE  | waiting for the core to raise USR_BUSY
// WAIT_FALL  | waiting for USR_BUSY to drop; check USR_CMD_ERROR
// RD_SETUP   | APB setup phase of mailbox read k
// RD_ACCESS  | APB access phase of mailbox read k
// DONE       | done/err pulse, release grant, advance pointer
module sysserv_sequencer
  import sysserv_pkg::*;
#(
  parameter int          NREQ        = 3,
  parameter logic [31:0] CMD_ADDR    = CMD_ADDR_DFLT,
  parameter logic [31:0] MBX_BASE    = MBX_BASE_DFLT,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_opcode,
  input  logic [4*NREQ-1:0] req_rdlen,
  output logic [NREQ-1:0]   grant,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              APBM_PSEL,
  output logic              APBM_PENABLE,
  output logic              APBM_PWRITE,
  output logic [31:0]       APBM_PADDR,
  output logic [31:0]       APBM_PWDATA,
  input  logic [31:0]       APBM_PRDATA,
  input  logic              APBM_PREADY,
  input  logic              APBM_PSLVERR,
  input  logic              USR_BUSY,
  input  logic              USR_CMD_ERROR,
  input  logic              SS_BUSY
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("NREQ must be in 2..8");
  end
  if (TIMEOUT_CYC == 24'd0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be nonzero");
  end

  state_t          state;
  logic [IW-1:0]   owner;
  logic [7:0]      opcode_q;
  logic [3:0]      rdlen_q;
  logic [3:0]      k;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            waiting;
  logic            to_hit;

  assign waiting = (state == ST_WAIT_RISE) || (state == ST_WAIT_FALL);

  sysserv_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk     (CLK),
    .rst_n   (RESETN),
    .req     (req),
    .advance (state == ST_DONE),
    .winner  (owner),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .any     (arb_any)
  );

`ifdef SYSSERV_TIMEOUT_EN
  logic [23:0] to_cnt;

  // Down-counter armed during the command access; expires after TIMEOUT_CYC wait cycles.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) to_cnt <= '0;
    else if (state == ST_CMD_ACCESS) to_cnt <= TIMEOUT_CYC - 24'd1;
    else if (waiting && to_cnt != 24'd0) to_cnt <= to_cnt - 24'd1;
  end

  assign to_hit = waiting && (to_cnt == 24'd0);
`else
  assign to_hit = 1'b0;
`endif

  // APB outputs decode straight from state so a reset clears them at once.
  always_comb begin
    APBM_PSEL    = 1'b0;
    APBM_PENABLE = 1'b0;
    APBM_PWRITE  = 1'b0;
    APBM_PADDR   = 32'd0;
    APBM_PWDATA  = 32'd0;
    case (state)
      ST_CMD_SETUP, ST_CMD_ACCESS: begin
        APBM_PSEL    = 1'b1;
        APBM_PENABLE = (state == ST_CMD_ACCESS);
        APBM_PWRITE  = 1'b1;
        APBM_PADDR   = CMD_ADDR;
        APBM_PWDATA  = {24'd0, opcode_q};
      end
      ST_RD_SETUP, ST_RD_ACCESS: begin
        APBM_PSEL    = 1'b1;
        APBM_PENABLE = (state == ST_RD_ACCESS);
        APBM_PADDR   = mbx_addr(MBX_BASE, k);
      end
      default: ;
    endcase
  end

  // Transaction sequencer; done and err are set on the edge into DONE.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= ST_IDLE;
      grant    <= '0;
      owner    <= '0;
      opcode_q <= '0;
      rdlen_q  <= '0;
      k        <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any && !SS_BUSY) begin
            grant    <= arb_grant;
            owner    <= arb_idx;
            opcode_q <= req_opcode[int'(arb_idx)*8 +: 8];
            rdlen_q  <= req_rdlen[int'(arb_idx)*4 +: 4];
            k        <= '0;
            state    <= ST_CMD_SETUP;
          end
        end
        ST_CMD_SETUP: state <= ST_CMD_ACCESS;
        ST_CMD_ACCESS: begin
          if (APBM_PREADY) begin
            if (APBM_PSLVERR) begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= ST_WAIT_RISE;
            end
          end
        end
        ST_WAIT_RISE: begin
          if (USR_BUSY) begin
            state <= ST_WAIT_FALL;
          end else if (to_hit) begin
            state <= ST_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        ST_WAIT_FALL: begin
          if (!USR_BUSY) begin
            if (USR_CMD_ERROR || rdlen_q == 4'd0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= USR_CMD_ERROR;
            end else begin
              state <= ST_RD_SETUP;
              k     <= '0;
            end
          end else if (to_hit) begin
            state <= ST_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        ST_RD_SETUP: state <= ST_RD_ACCESS;
        ST_RD_ACCESS: begin
          if (APBM_PREADY) begin
            if (APBM_PSLVERR) begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              rd_data  <= APBM_PRDATA;
              rd_valid <= 1'b1;
              k        <= k + 4'd1;
              if ((k + 4'd1) == rdlen_q) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state <= ST_RD_SETUP;
              end
            end
          end
        end
        ST_DONE: begin
          grant <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysserv_sequencer.sv
// Directed bench for sysserv_sequencer with a small APB mailbox model
// (word k reads 32'hA0 + k) and a service-core busy model.
module tb_sysserv_sequencer;
  import sysserv_pkg::*;

  localparam int NREQ = 3;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [8*NREQ-1:0] req_opcode = '0;
  logic [4*NREQ-1:0] req_rdlen = '0;
  logic [NREQ-1:0] grant;
  logic [31:0] rd_data;
  logic rd_valid, done, err;
  logic psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic pready, pslverr;
  logic usr_busy, usr_cmd_error;
  logic ss_busy = 1'b0;

  logic stuck_busy = 1'b0;
  logic cmd_err = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int busy_cnt = 0;

  int n_tests = 0;
  int n_fail = 0;

  int rd_cnt, rda_cnt, wr_cnt, done_cnt, g_cnt, lat, last_lat, gap;
  logic [31:0] rd_words [16];
  logic [31:0] rd_addrs [16];
  logic [31:0] last_wdata, last_waddr, max_rd_addr;
  logic [NREQ-1:0] g_seq [8];
  int g_gap [8];
  logic [NREQ-1:0] prev_grant = '0;
  logic last_err;

  always #5 CLK = ~CLK;

  assign pready        = 1'b1;
  assign pslverr       = psel && penable && (paddr == err_addr);
  assign prdata        = 32'hA0 + ((paddr - 32'h100) >> 2);
  assign usr_busy      = stuck_busy || (busy_cnt > 0);
  assign usr_cmd_error = cmd_err;

  sysserv_sequencer #(.NREQ(NREQ), .TIMEOUT_CYC(24'd100)) dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .req           (req),
    .req_opcode    (req_opcode),
    .req_rdlen     (req_rdlen),
    .grant         (grant),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .done          (done),
    .err           (err),
    .APBM_PSEL     (psel),
    .APBM_PENABLE  (penable),
    .APBM_PWRITE   (pwrite),
    .APBM_PADDR    (paddr),
    .APBM_PWDATA   (pwdata),
    .APBM_PRDATA   (prdata),
    .APBM_PREADY   (pready),
    .APBM_PSLVERR  (pslverr),
    .USR_BUSY      (usr_busy),
    .USR_CMD_ERROR (usr_cmd_error),
    .SS_BUSY       (ss_busy)
  );

  // Core busy model and bus/output monitor, both at the falling edge.
  always @(negedge CLK) begin
    if (psel && penable && pwrite && pready) begin
      busy_cnt = 2;
      wr_cnt++;
      last_wdata = pwdata;
      last_waddr = paddr;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    if (psel && !penable && !pwrite) begin
      if (rda_cnt < 16) rd_addrs[rda_cnt] = paddr;
      rda_cnt++;
      if (paddr > max_rd_addr) max_rd_addr = paddr;
    end
    if (rd_valid) begin
      if (rd_cnt < 16) rd_words[rd_cnt] = rd_data;
      rd_cnt++;
    end
    if (grant != '0 && prev_grant == '0) begin
      if (g_cnt < 8) begin
        g_seq[g_cnt] = grant;
        g_gap[g_cnt] = gap;
      end
      g_cnt++;
      lat = 1;
    end else if (grant != '0) begin
      lat++;
    end
    if (grant == '0) gap++;
    else gap = 0;
    if (done) begin
      done_cnt++;
      last_err = err;
      last_lat = lat;
    end
    prev_grant = grant;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_mon();
    rd_cnt = 0; rda_cnt = 0; wr_cnt = 0; done_cnt = 0; g_cnt = 0;
    max_rd_addr = 0; last_wdata = 32'hDEAD_BEEF; last_waddr = 32'hDEAD_BEEF;
    last_err = 1'bx; last_lat = -1;
  endtask

  task automatic wait_done_n(input string tag, input int target, input int max_cyc);
    int n;
    n = 0;
    while (done_cnt < target && n < max_cyc) begin
      step(1);
      n++;
    end
    chk(tag, done_cnt, target);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_apbctl"}, {psel, penable, pwrite}, 0);
    chk({tag, "_paddr"}, paddr, 0);
    chk({tag, "_pwdata"}, pwdata, 0);
    chk({tag, "_flags"}, {rd_valid, done, err}, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    step(2);
    chk_outputs_zero("reset");
    RESETN = 1'b1;
    step(2);

    // Single SN request, 4 mailbox words
    clear_mon();
    req_opcode[7:0] = OP_SN;
    req_rdlen[3:0]  = 4'd4;
    req = 3'b001;
    step(1);
    chk("t1_grant", grant, 3'b001);
    chk("t1_apbctl", {psel, penable, pwrite}, 3'b101);
    chk("t1_paddr", paddr, 32'h0);
    wait_done_n("t1_done", 1, 60);
    req = 3'b000;
    chk("t1_wr_cnt", wr_cnt, 1);
    chk("t1_wdata", last_wdata, 32'h0000_0000);
    chk("t1_waddr", last_waddr, 32'h0);
    chk("t1_rd_addrs", rda_cnt, 4);
    chk("t1_rd_cnt", rd_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_rd_addr", rd_addrs[i], 32'h100 + 4 * i);
      chk("t1_rd_word", rd_words[i], 32'hA0 + i);
    end
    chk("t1_err", last_err, 0);
    chk("t1_latency", last_lat, 13);
    step(3);

    // Command error from requester 2 (IAP)
    clear_mon();
    req_opcode[23:16] = OP_IAP;
    req_rdlen[11:8]   = 4'd2;
    cmd_err = 1'b1;
    req = 3'b100;
    wait_done_n("t3_done", 1, 60);
    req = 3'b000;
    cmd_err = 1'b0;
    chk("t3_grant", g_seq[0], 3'b100);
    chk("t3_wdata", last_wdata, 32'h42);
    chk("t3_err", last_err, 1);
    chk("t3_rd_cnt", rd_cnt, 0);
    chk("t3_rd_addrs", rda_cnt, 0);
    step(3);

    // All three requesting, rdlen 0: rotation and 1-cycle gaps
    clear_mon();
    req_rdlen = '0;
    req = 3'b111;
    wait_done_n("t2_done", 4, 100);
    req = 3'b000;
    chk("t2_grant0", g_seq[0], 3'b001);
    chk("t2_grant1", g_seq[1], 3'b010);
    chk("t2_grant2", g_seq[2], 3'b100);
    chk("t2_grant3", g_seq[3], 3'b001);
    for (int i = 1; i < 4; i++) chk("t2_gap", g_gap[i], 1);
    chk("t2_latency", last_lat, 5);
    chk("t2_err", last_err, 0);
    chk("t2_rd_cnt", rd_cnt, 0);
    chk("t2_wr_cnt", wr_cnt, 4);
    step(3);

    // PSLVERR on second mailbox read
    clear_mon();
    req_rdlen[7:4] = 4'd3;
    err_addr = 32'h104;
    req = 3'b010;
    wait_done_n("t4_done", 1, 60);
    req = 3'b000;
    err_addr = 32'hFFFF_FFFF;
    chk("t4_grant", g_seq[0], 3'b010);
    chk("t4_rd_cnt", rd_cnt, 1);
    chk("t4_word0", rd_words[0], 32'hA0);
    chk("t4_err", last_err, 1);
    chk("t4_max_addr", max_rd_addr, 32'h104);
    step(3);

    // SS_BUSY holds off arbitration; PSLVERR on the command write
    clear_mon();
    req_opcode[7:0] = OP_DV;
    req_rdlen[3:0]  = 4'd1;
    err_addr = 32'h0;
    ss_busy = 1'b1;
    req = 3'b001;
    step(5);
    chk("t5_ss_busy_hold", grant, 0);
    ss_busy = 1'b0;
    step(1);
    chk("t5_grant", grant, 3'b001);
    wait_done_n("t5_done", 1, 30);
    req = 3'b000;
    err_addr = 32'hFFFF_FFFF;
    chk("t5_wdata", last_wdata, 32'h44);
    chk("t5_err", last_err, 1);
    chk("t5_rd_addrs", rda_cnt, 0);
    chk("t5_latency", last_lat, 3);
    step(3);

    // USR_BUSY stuck high
    clear_mon();
    req_rdlen[3:0] = 4'd0;
    stuck_busy = 1'b1;
    req = 3'b001;
`ifdef SYSSERV_TIMEOUT_EN
    wait_done_n("t6_done", 1, 300);
    req = 3'b000;
    stuck_busy = 1'b0;
    chk("t6_err", last_err, 1);
    chk("t6_latency", last_lat, 103);
`else
    step(10000);
    chk("t6_no_done", done_cnt, 0);
    chk("t6_grant_held", grant, 3'b001);
    stuck_busy = 1'b0;
    wait_done_n("t6_done", 1, 20);
    req = 3'b000;
    chk("t6_err", last_err, 0);
`endif
    step(3);

    // Asynchronous reset during a mailbox read
    clear_mon();
    req_rdlen[7:4] = 4'd2;
    req = 3'b010;
    begin
      int n;
      n = 0;
      while (!(psel && penable && !pwrite) && n < 50) begin
        step(1);
        n++;
      end
      chk("t7_reach_rd", {psel, penable, pwrite}, 3'b110);
    end
    #2;
    RESETN = 1'b0;
    #1;
    chk_outputs_zero("t7_async");
    req = 3'b011;
    step(2);
    RESETN = 1'b1;
    step(1);
    chk("t7_first_grant", grant, 3'b001);
    chk("t7_no_done", done_cnt, 0);
    wait_done_n("t7_done", 1, 30);
    req = 3'b000;
    chk("t7_err", last_err, 0);
    step(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
